// File: rtl/lbp_img_host_if.sv
// ---------------------------------------------------------------------------
// lbp_img_host_if
//   Bundle of every non-clock signal between the LBP image host and its
//   environment (image loader, LBP core, result reader).
//
//   Loader side      : ld_valid, ld_addr, ld_data, ld_done
//   Gray pixel port  : gray_req, gray_addr -> gray_ready, gray_data
//   LBP result port  : lbp_valid, lbp_addr, lbp_data, finish
//                      -> done, wr_count
//   Result readback  : rd_addr -> rd_data
//   Status           : border_err
//
//   master : the environment (core + loader + reader) driving requests
//   slave  : the lbp_img_host memory side
// ---------------------------------------------------------------------------
interface lbp_img_host_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 15
);
  logic              ld_valid;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_data;
  logic              ld_done;

  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic              gray_ready;
  logic [DATA_W-1:0] gray_data;

  logic              lbp_valid;
  logic [ADDR_W-1:0] lbp_addr;
  logic [DATA_W-1:0] lbp_data;
  logic              finish;
  logic              done;
  logic [CNT_W-1:0]  wr_count;

  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;

  logic              border_err;

  modport master (
    output ld_valid, ld_addr, ld_data, ld_done,
    output gray_req, gray_addr,
    output lbp_valid, lbp_addr, lbp_data, finish,
    output rd_addr,
    input  gray_ready, gray_data, done, wr_count, rd_data, border_err
  );

  modport slave (
    input  ld_valid, ld_addr, ld_data, ld_done,
    input  gray_req, gray_addr,
    input  lbp_valid, lbp_addr, lbp_data, finish,
    input  rd_addr,
    output gray_ready, gray_data, done, wr_count, rd_data, border_err
  );
endinterface

// File: rtl/lbp_img_host.sv
// ---------------------------------------------------------------------------
// lbp_img_host
//   Memory-side environment of the LBP engine. Holds a 128x128 gray image
//   (loaded through the ld_* write port) and a 128x128 LBP result buffer
//   (written by the core through lbp_*). Results are frozen once the core
//   raises finish and can then be read back through rd_addr/rd_data.
//
//   Ports
//     clk    : rising-edge clock
//     reset  : synchronous, active-high reset
//     bus    : lbp_img_host_if.slave (loader, gray, lbp, readback, status)
//
//   Optional feature
//     LBP_BORDER_CHECK_EN : when defined, border_err becomes a sticky flag
//                           set by any accepted result write that lands on
//                           the outer ring of the image (row or column 0 or
//                           127). When undefined border_err is tied low.
//
//   State  | meaning
//   -------+-------------------------------------------------------------
//   LOAD   | image being written, gray/lbp ports ignored
//   SERVE  | gray reads served, result writes captured and counted
//   DONE   | results frozen, done=1, held until reset
//
//   Memory contents survive reset; only control state is cleared.
// ---------------------------------------------------------------------------
module lbp_img_host #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 15
) (
  input  logic          clk,
  input  logic          reset,
  lbp_img_host_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int COL_W = 7;
  localparam int ROW_W = ADDR_W - COL_W;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_SERVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_gray_ready;
  logic [DATA_W-1:0] r_gray_data;
  logic              r_done;
  logic [CNT_W-1:0]  r_wr_count;
  logic [DATA_W-1:0] r_rd_data;

  logic [DATA_W-1:0] r_gray_mem [DEPTH];
  logic [DATA_W-1:0] r_lbp_mem  [DEPTH];

  logic w_gray_we;
  logic w_lbp_we;
  logic w_cnt_max;

  // Writes are qualified by state here so both memories and the FSM agree
  // on which cycles are accepted; reset blocks writes in its own cycle.
  assign w_gray_we = !reset && (r_state == S_LOAD)  && bus.ld_valid;
  assign w_lbp_we  = !reset && (r_state == S_SERVE) && bus.lbp_valid;
  assign w_cnt_max = &r_wr_count;

  always_ff @(posedge clk) begin
    if (w_gray_we) begin
      r_gray_mem[bus.ld_addr] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_lbp_we) begin
      r_lbp_mem[bus.lbp_addr] <= bus.lbp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_LOAD;
      r_gray_ready <= 1'b0;
      r_gray_data  <= '0;
      r_done       <= 1'b0;
      r_wr_count   <= '0;
    end else begin
      case (r_state)
        S_LOAD: begin
          // A write coinciding with ld_done is taken by the memory block.
          if (bus.ld_done) begin
            r_state      <= S_SERVE;
            r_gray_ready <= 1'b1;
          end
        end
        S_SERVE: begin
          if (bus.gray_req) begin
            r_gray_data <= r_gray_mem[bus.gray_addr];
          end
          if (bus.lbp_valid && !w_cnt_max) begin
            r_wr_count <= r_wr_count + CNT_ONE;
          end
          // The write in the finish cycle is still captured above; from
          // DONE onward the core's lingering lbp_valid is ignored.
          if (bus.finish) begin
            r_state      <= S_DONE;
            r_gray_ready <= 1'b0;
            r_done       <= 1'b1;
          end
        end
        S_DONE: begin
          r_gray_ready <= 1'b0;
          r_done       <= 1'b1;
        end
        default: begin
          r_state      <= S_LOAD;
          r_gray_ready <= 1'b0;
          r_done       <= 1'b0;
        end
      endcase
    end
  end

  // Readback runs in every state; it is only meaningful once done=1.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_data <= '0;
    end else begin
      r_rd_data <= r_lbp_mem[bus.rd_addr];
    end
  end

`ifdef LBP_BORDER_CHECK_EN
  logic             r_border_err;
  logic [ROW_W-1:0] w_row;
  logic [COL_W-1:0] w_col;
  logic             w_on_border;

  assign w_row       = bus.lbp_addr[ADDR_W-1:COL_W];
  assign w_col       = bus.lbp_addr[COL_W-1:0];
  assign w_on_border = (w_row == '0) || (w_row == '1) ||
                       (w_col == '0) || (w_col == '1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_border_err <= 1'b0;
    end else if (w_lbp_we && w_on_border) begin
      r_border_err <= 1'b1;
    end
  end

  assign bus.border_err = r_border_err;
`else
  assign bus.border_err = 1'b0;
`endif

  assign bus.gray_ready = r_gray_ready;
  assign bus.gray_data  = r_gray_data;
  assign bus.done       = r_done;
  assign bus.wr_count   = r_wr_count;
  assign bus.rd_data    = r_rd_data;

endmodule

// File: tb/tb_lbp_img_host.sv
module tb_lbp_img_host;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 15;
  localparam int NPIX   = 1 << ADDR_W;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

`ifdef LBP_BORDER_CHECK_EN
  localparam logic BORDER_EN = 1'b1;
`else
  localparam logic BORDER_EN = 1'b0;
`endif

  localparam int M_LOAD  = 0;
  localparam int M_SERVE = 1;
  localparam int M_DONE  = 2;

  typedef struct packed {
    logic        ldv;
    logic [13:0] lda;
    logic [7:0]  ldd;
    logic        ldn;
    logic        greq;
    logic [13:0] ga;
    logic        lv;
    logic [13:0] la;
    logic [7:0]  ld;
    logic        fin;
    logic        rchk;
    logic [13:0] ra;
  } stim_t;

  logic clk = 1'b0;
  logic reset;
  logic rd_chk;

  always #5 clk = ~clk;

  lbp_img_host_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  lbp_img_host #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // reference model
  logic [7:0] gm [NPIX];
  logic [7:0] lm [NPIX];
  bit         lw [NPIX];
  int         wlist[$];
  int         m_state;
  int         m_cnt;
  bit         m_border;
  logic [7:0] m_gd;

  logic [7:0] gray_q[$];
  logic [7:0] rd_q[$];

  int vec_cnt = 0;
  int err_cnt = 0;

  function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic bit on_border(input int a);
    int row, col;
    row = a / 128;
    col = a % 128;
    return (row == 0) || (row == 127) || (col == 0) || (col == 127);
  endfunction

  function automatic logic [13:0] pick_lbp_addr();
    if (wlist.size() > 0 && $urandom_range(0, 1) == 1)
      return 14'(wlist[$urandom_range(0, wlist.size() - 1)]);
    return 14'($urandom);
  endfunction

  task automatic drive_idle();
    bus.ld_valid  = 1'b0; bus.ld_addr  = '0; bus.ld_data  = '0; bus.ld_done = 1'b0;
    bus.gray_req  = 1'b0; bus.gray_addr = '0;
    bus.lbp_valid = 1'b0; bus.lbp_addr = '0; bus.lbp_data = '0; bus.finish = 1'b0;
    bus.rd_addr   = '0;
    rd_chk        = 1'b0;
  endtask

  // One clock of stimulus; returns 1 time unit after the rising edge.
  task automatic step(input stim_t s);
    @(negedge clk);
    reset         = 1'b0;
    bus.ld_valid  = s.ldv;  bus.ld_addr   = s.lda; bus.ld_data  = s.ldd; bus.ld_done = s.ldn;
    bus.gray_req  = s.greq; bus.gray_addr = s.ga;
    bus.lbp_valid = s.lv;   bus.lbp_addr  = s.la;  bus.lbp_data = s.ld;  bus.finish  = s.fin;
    bus.rd_addr   = s.ra;
    rd_chk        = s.rchk;
    if (s.rchk) rd_q.push_back(lm[s.ra]);
    if (m_state == M_LOAD) begin
      if (s.ldv) gm[s.lda] = s.ldd;
      if (s.ldn) m_state = M_SERVE;
    end else if (m_state == M_SERVE) begin
      if (s.greq) begin
        m_gd = gm[s.ga];
        gray_q.push_back(m_gd);
      end
      if (s.lv) begin
        lm[s.la] = s.ld;
        if (!lw[s.la]) begin
          lw[s.la] = 1'b1;
          wlist.push_back(int'(s.la));
        end
        if (m_cnt < CNT_SAT) m_cnt++;
        if (on_border(int'(s.la))) m_border = 1'b1;
      end
      if (s.fin) m_state = M_DONE;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_step();
    stim_t s;
    s = '0;
    step(s);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    drive_idle();
    reset = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    m_state  = M_LOAD;
    m_cnt    = 0;
    m_border = 1'b0;
    m_gd     = 8'h00;
  endtask

  task automatic rd_check(input int a);
    stim_t s;
    s = '0;
    s.rchk = 1'b1;
    s.ra   = 14'(a);
    step(s);
  endtask

  // Monitor: gray_data is presented the cycle after an accepted request,
  // rd_data the cycle after the read address is applied.
  initial begin
    logic rdy_seen;
    logic greq_s, rchk_s;
    logic [7:0] e;
    rdy_seen = 1'b0;
    forever begin
      @(posedge clk);
      greq_s = bus.gray_req;
      rchk_s = rd_chk;
      #1;
      if (greq_s && rdy_seen) begin
        if (gray_q.size() == 0) begin
          vec_cnt++; err_cnt++;
          $display("FAIL gray_unexpected: got response 0x%0h, expected none", bus.gray_data);
        end else begin
          e = gray_q.pop_front();
          cmp("gray_data", 32'(bus.gray_data), 32'(e));
        end
      end
      if (rchk_s) begin
        if (rd_q.size() == 0) begin
          vec_cnt++; err_cnt++;
          $display("FAIL rd_unexpected: got 0x%0h, expected none", bus.rd_data);
        end else begin
          e = rd_q.pop_front();
          cmp("rd_data", 32'(bus.rd_data), 32'(e));
        end
      end
      rdy_seen = bus.gray_ready;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    stim_t s;
    int prev;
    reset = 1'b1;
    drive_idle();
    m_state = M_LOAD; m_cnt = 0; m_border = 1'b0; m_gd = 8'h00;
    repeat (3) @(posedge clk);
    #1;

    cmp("rst_gray_ready", 32'(bus.gray_ready), 0);
    cmp("rst_gray_data",  32'(bus.gray_data), 0);
    cmp("rst_done",       32'(bus.done), 0);
    cmp("rst_wr_count",   32'(bus.wr_count), 0);
    cmp("rst_rd_data",    32'(bus.rd_data), 0);
    cmp("rst_border_err", 32'(bus.border_err), 0);

    // full image load, gray_req/lbp_valid noise must be ignored
    for (int a = 0; a < NPIX; a++) begin
      s = '0;
      s.ldv  = 1'b1;
      s.lda  = 14'(a);
      s.ldd  = 8'(a % 256);
      s.ldn  = (a == NPIX - 1);
      s.greq = 1'($urandom_range(0, 1));
      s.ga   = 14'($urandom);
      s.lv   = ($urandom_range(0, 3) == 0);
      s.la   = 14'($urandom);
      s.ld   = 8'($urandom);
      step(s);
      if (a == NPIX - 2) cmp("ready_before_ld_done", 32'(bus.gray_ready), 0);
    end
    cmp("ready_after_ld_done", 32'(bus.gray_ready), 1);
    cmp("wr_count_after_load", 32'(bus.wr_count), 0);

    // read latency, plus an ld_valid in SERVE that must be ignored
    s = '0;
    s.greq = 1'b1; s.ga = 14'h0081;
    s.ldv = 1'b1; s.lda = 14'h0081; s.ldd = 8'h00;
    step(s);
    cmp("gray_0081", 32'(bus.gray_data), 32'h81);
    idle_step();
    idle_step();
    cmp("gray_hold", 32'(bus.gray_data), 32'h81);

    // capture with overwrite
    s = '0; s.lv = 1'b1; s.la = 14'h0081; s.ld = 8'h5A; step(s);
    s = '0; s.lv = 1'b1; s.la = 14'h0082; s.ld = 8'hA5; step(s);
    s = '0; s.lv = 1'b1; s.la = 14'h0081; s.ld = 8'h0F; step(s);
    cmp("wr_count_3", 32'(bus.wr_count), 3);
    cmp("border_interior", 32'(bus.border_err), 0);

    s = '0; s.lv = 1'b1; s.la = 14'h0080; s.ld = 8'h33; step(s);
    cmp("border_col0", 32'(bus.border_err), 32'(BORDER_EN));
    idle_step();
    cmp("border_sticky", 32'(bus.border_err), 32'(BORDER_EN));

    // randomized SERVE traffic
    for (int i = 0; i < 400; i++) begin
      s = '0;
      s.greq = 1'($urandom_range(0, 1));
      s.ga   = 14'($urandom);
      s.lv   = 1'($urandom_range(0, 1));
      s.la   = pick_lbp_addr();
      s.ld   = 8'($urandom);
      s.ldv  = 1'($urandom_range(0, 1));
      s.lda  = 14'($urandom);
      s.ldd  = 8'($urandom);
      if ($urandom_range(0, 3) == 0 && wlist.size() > 0) begin
        s.rchk = 1'b1;
        s.ra   = 14'(wlist[$urandom_range(0, wlist.size() - 1)]);
      end
      step(s);
    end
    cmp("wr_count_random", 32'(bus.wr_count), 32'(m_cnt));
    cmp("border_random", 32'(bus.border_err), 32'(BORDER_EN & m_border));

    // finish overlapping a write, then lbp_valid held high
    prev = m_cnt;
    s = '0; s.lv = 1'b1; s.la = 14'h3F7E; s.ld = 8'hFF; s.fin = 1'b1;
    step(s);
    for (int i = 0; i < 10; i++) begin
      s = '0;
      s.lv   = 1'b1;
      s.la   = (i == 0) ? 14'h0081 : pick_lbp_addr();
      s.ld   = 8'($urandom);
      s.fin  = 1'b1;
      s.greq = 1'($urandom_range(0, 1));
      s.ga   = 14'($urandom);
      step(s);
    end
    cmp("wr_count_finish", 32'(bus.wr_count), 32'(prev + 1));
    cmp("done_set", 32'(bus.done), 1);
    cmp("ready_in_done", 32'(bus.gray_ready), 0);
    cmp("gray_hold_done", 32'(bus.gray_data), 32'(m_gd));

    rd_check(32'h0081);
    cmp("rd_0081", 32'(bus.rd_data), 32'(lm[14'h0081]));
    rd_check(32'h3F7E);
    cmp("rd_3F7E", 32'(bus.rd_data), 32'hFF);
    foreach (wlist[i]) rd_check(wlist[i]);

    // reset after DONE, reload part of the image, lbp noise during LOAD
    do_reset(1);
    cmp("rst2_wr_count", 32'(bus.wr_count), 0);
    cmp("rst2_done", 32'(bus.done), 0);
    cmp("rst2_ready", 32'(bus.gray_ready), 0);
    cmp("rst2_rd_data", 32'(bus.rd_data), 0);
    for (int i = 0; i < 300; i++) begin
      s = '0;
      s.ldv  = 1'($urandom_range(0, 1)) | (i == 299);
      s.lda  = 14'($urandom);
      s.ldd  = 8'($urandom);
      s.ldn  = (i == 299);
      s.greq = 1'($urandom_range(0, 1));
      s.ga   = 14'($urandom);
      s.lv   = 1'($urandom_range(0, 1));
      s.la   = 14'(wlist[$urandom_range(0, wlist.size() - 1)]);
      s.ld   = 8'($urandom);
      step(s);
    end
    cmp("ready_reload", 32'(bus.gray_ready), 1);
    for (int i = 0; i < 60; i++) begin
      s = '0;
      s.greq = 1'($urandom_range(0, 1));
      s.ga   = 14'($urandom);
      step(s);
    end
    for (int i = 0; i < 5; i++) begin
      s = '0;
      s.lv = 1'b1;
      s.la = 14'($urandom);
      s.ld = 8'($urandom);
      step(s);
    end
    cmp("wr_count_5", 32'(bus.wr_count), 5);

    // reset mid-SERVE
    do_reset(1);
    cmp("rst3_wr_count", 32'(bus.wr_count), 0);
    cmp("rst3_done", 32'(bus.done), 0);
    cmp("rst3_ready", 32'(bus.gray_ready), 0);
    cmp("rst3_border", 32'(bus.border_err), 0);
    s = '0; s.greq = 1'b1; s.ga = 14'h0081; step(s);
    cmp("ready_load_again", 32'(bus.gray_ready), 0);
    foreach (wlist[i]) rd_check(wlist[i]);

    idle_step();
    idle_step();
    cmp("gray_q_drained", 32'(gray_q.size()), 0);
    cmp("rd_q_drained", 32'(rd_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/lbp_img_host.md
Name: lbp_img_host

Overview:
- Memory-side counterpart of the LBP engine: serves gray pixel requests on the gray_* interface and captures LBP results on the lbp_* interface.
- Holds a 128x128 gray image, loaded over a simple write port, and a 128x128 LBP result buffer.
- The result buffer is read back after the engine raises finish.
- Sits between the testbench/system loader and the LBP core; makes the core's environment synthesizable.

Parameters:
- ADDR_W, 14, pixel address width (image = 2^ADDR_W pixels, row-major, 128 per row)
- DATA_W, 8, pixel and LBP code width
- CNT_W, 15, width of the result write counter (must hold 2^ADDR_W)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- ld_valid  in  1  gray image load strobe
- ld_addr  in  ADDR_W  load address
- ld_data  in  DATA_W  load pixel
- ld_done  in  1  one-cycle pulse: image fully loaded
- gray_req  in  1  pixel request from the LBP core
- gray_addr  in  ADDR_W  requested pixel address
- gray_ready  out  1  image available for reading
- gray_data  out  DATA_W  requested pixel, registered
- lbp_valid  in  1  result write strobe
- lbp_addr  in  ADDR_W  result address
- lbp_data  in  DATA_W  LBP code
- finish  in  1  LBP core completion
- done  out  1  results frozen and readable
- wr_count  out  CNT_W  number of accepted result writes
- rd_addr  in  ADDR_W  result readback address
- rd_data  out  DATA_W  result readback data, registered
- border_err  out  1  sticky border-write flag (optional feature only)

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high. All state updates occur on rising clk.
- Reset values: gray_ready=0, gray_data=0, done=0, wr_count=0, rd_data=0, border_err=0, state=LOAD. Memory contents are not cleared.
- FSM has three states:
  - LOAD -> SERVE on ld_done.
  - SERVE -> DONE on the first cycle finish=1.
  - DONE holds until reset.
- LOAD:
  - ld_valid=1 writes gray_mem[ld_addr]=ld_data.
  - ld_valid and ld_done in the same cycle: the write is performed and the FSM still transitions.
  - gray_req and lbp_valid are ignored.
- SERVE:
  - gray_ready=1, asserted the cycle after the ld_done edge.
  - Every cycle with gray_req=1: gray_data <= gray_mem[gray_addr] (1-cycle read latency).
  - gray_req=0: gray_data holds its value.
  - ld_valid is ignored.
- Result capture (SERVE only):
  - lbp_valid=1 writes lbp_mem[lbp_addr]=lbp_data and increments wr_count.
  - Rewrites to the same address overwrite the entry and still count.
  - wr_count saturates at 2^CNT_W-1.
- Finish cycle:
  - If lbp_valid=1 in the same cycle finish first rises, that write is captured and counted.
  - Then the FSM enters DONE.
- DONE:
  - done=1, gray_ready=0.
  - lbp_valid is ignored. The LBP core keeps lbp_valid high after finish, and no further writes or counts may occur.
  - gray_data holds its value.
- Readback:
  - rd_data <= lbp_mem[rd_addr] every cycle (1-cycle latency) in all states.
  - Readback is only meaningful when done=1.
- Reset mid-operation: return to LOAD, drop gray_ready and done, clear wr_count and border_err. A reload is required before serving again.
- Address arithmetic: addresses are used unmodified, with no wrap logic; 2^ADDR_W covers the full image.

Optional Feature:
- Macro: LBP_BORDER_CHECK_EN.
- Defined: border_err is set (sticky until reset) when an accepted result write has row (lbp_addr[13:7]) of 0 or 127, or column (lbp_addr[6:0]) of 0 or 127. The write itself is still performed.
- Undefined: border_err is tied to 0 and no compare logic is built.

Test Plan:
- Load: write pixels 0..16383 with value addr[7:0], pulse ld_done -> gray_ready=1 on the next cycle; before ld_done, gray_ready=0 and gray_req is ignored.
- Read latency: in SERVE, gray_req=1 with gray_addr=0x0081 -> gray_data=0x81 one cycle later; then gray_req=0 -> gray_data stays 0x81.
- Capture: lbp_valid with addr 0x0081/data 0x5A, then 0x0082/0xA5, then 0x0081/0x0F -> wr_count=3; after done, rd_addr=0x0081 -> rd_data=0x0F one cycle later.
- Finish overlap: finish=1 and lbp_valid=1 (addr 0x3F7E, data 0xFF) in the same cycle, then lbp_valid held high for 10 cycles -> that write is captured, wr_count increments by 1 only, done=1, gray_ready=0.
- Reset mid-SERVE after 5 writes: reset for 1 cycle -> wr_count=0, done=0, gray_ready=0, state LOAD; earlier lbp_mem contents are still readable.
- LBP_BORDER_CHECK_EN defined: write to lbp_addr 0x0080 (column 0) -> border_err=1 and stays 1. Macro undefined: same write -> border_err=0.
